// File: rtl/eth_header_fifo.sv
// eth_header_fifo: first-word-fall-through FIFO of Ethernet header beats with occupancy, almost-full, flush and optional VLAN TCI.
module eth_header_fifo #(
  parameter int DEPTH     = 16,
  parameter int VLAN_EN   = 0,
  parameter int AF_THRESH = 12
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         s_hdr_valid,
  output logic                         s_hdr_ready,
  input  logic [47:0]                  s_hdr_dest_mac,
  input  logic [47:0]                  s_hdr_src_mac,
  input  logic [15:0]                  s_hdr_eth_type,
  input  logic [15:0]                  s_hdr_vlan_tci,
  output logic                         m_hdr_valid,
  input  logic                         m_hdr_ready,
  output logic [47:0]                  m_hdr_dest_mac,
  output logic [47:0]                  m_hdr_src_mac,
  output logic [15:0]                  m_hdr_eth_type,
  output logic [15:0]                  m_hdr_vlan_tci,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int W  = (VLAN_EN != 0) ? 128 : 112;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  wr_word, rd_word;
  logic          push, pop;
  assign count          = count_q;
  assign s_hdr_ready    = !reset && (count_q != CW'(DEPTH));
  assign m_hdr_valid    = count_q != '0;
  assign almost_full    = count_q >= CW'(AF_THRESH);
  assign rd_word        = m_hdr_valid ? mem_q[rd_ptr_q] : '0;
  assign m_hdr_dest_mac = rd_word[47:0];
  assign m_hdr_src_mac  = rd_word[95:48];
  assign m_hdr_eth_type = rd_word[111:96];
  generate
    if (VLAN_EN != 0) begin : g_vlan
      assign wr_word        = {s_hdr_vlan_tci, s_hdr_eth_type, s_hdr_src_mac, s_hdr_dest_mac};
      assign m_hdr_vlan_tci = rd_word[W-1 -: 16];
    end else begin : g_novlan
      assign wr_word        = {s_hdr_eth_type, s_hdr_src_mac, s_hdr_dest_mac};
      assign m_hdr_vlan_tci = 16'h0000;
    end
  endgenerate
  // pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    push     = s_hdr_valid && s_hdr_ready;
    pop      = m_hdr_valid && m_hdr_ready;
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wr_word;
  end
endmodule

// File: tb/tb_eth_header_fifo.sv
// tb_eth_header_fifo: directed checks of eth_header_fifo ordering, full/almost-full, wrap, flush, reset and VLAN mode.
module tb_eth_header_fifo;
  logic        clk = 1'b0, reset = 1'b1, flush = 1'b0;
  logic        s_hdr_valid = 1'b0, m_hdr_ready = 1'b0;
  logic [47:0] s_hdr_dest_mac = '0, s_hdr_src_mac = '0;
  logic [15:0] s_hdr_eth_type = '0, s_hdr_vlan_tci = '0;
  logic        s_hdr_ready, m_hdr_valid, almost_full;
  logic [47:0] m_hdr_dest_mac, m_hdr_src_mac;
  logic [15:0] m_hdr_eth_type, m_hdr_vlan_tci;
  logic [4:0]  count;
  logic        v_s_ready, v_m_valid, v_af;
  logic [47:0] v_dest, v_src;
  logic [15:0] v_type, v_tci;
  logic [4:0]  v_count;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  eth_header_fifo #(.DEPTH(16), .VLAN_EN(0), .AF_THRESH(12)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
    .s_hdr_dest_mac(s_hdr_dest_mac), .s_hdr_src_mac(s_hdr_src_mac),
    .s_hdr_eth_type(s_hdr_eth_type), .s_hdr_vlan_tci(s_hdr_vlan_tci),
    .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready),
    .m_hdr_dest_mac(m_hdr_dest_mac), .m_hdr_src_mac(m_hdr_src_mac),
    .m_hdr_eth_type(m_hdr_eth_type), .m_hdr_vlan_tci(m_hdr_vlan_tci),
    .count(count), .almost_full(almost_full)
  );
  eth_header_fifo #(.DEPTH(16), .VLAN_EN(1), .AF_THRESH(12)) dut_v (
    .clk(clk), .reset(reset), .flush(flush),
    .s_hdr_valid(s_hdr_valid), .s_hdr_ready(v_s_ready),
    .s_hdr_dest_mac(s_hdr_dest_mac), .s_hdr_src_mac(s_hdr_src_mac),
    .s_hdr_eth_type(s_hdr_eth_type), .s_hdr_vlan_tci(s_hdr_vlan_tci),
    .m_hdr_valid(v_m_valid), .m_hdr_ready(m_hdr_ready),
    .m_hdr_dest_mac(v_dest), .m_hdr_src_mac(v_src),
    .m_hdr_eth_type(v_type), .m_hdr_vlan_tci(v_tci),
    .count(v_count), .almost_full(v_af)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [47:0] dest_of(input int id);
    return 48'h0A00_0000_0000 | 48'(id);
  endfunction
  task automatic set_hdr(input int id);
    s_hdr_dest_mac = dest_of(id);
    s_hdr_src_mac  = 48'h0200_0000_1000 | 48'(id);
    s_hdr_eth_type = 16'h0800 + 16'(id);
    s_hdr_vlan_tci = 16'h1000 + 16'(id);
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  initial begin
    cyc();
    chk("rst_s_ready", 64'(s_hdr_ready), 64'd0);
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_s_ready_rel", 64'(s_hdr_ready), 64'd1);
    chk("rst_m_valid", 64'(m_hdr_valid), 64'd0);
    chk("rst_af", 64'(almost_full), 64'd0);
    // single broadcast ARP header through an always-ready consumer
    s_hdr_dest_mac = 48'hFFFF_FFFF_FFFF;
    s_hdr_src_mac  = 48'h0200_0000_0001;
    s_hdr_eth_type = 16'h0806;
    s_hdr_valid = 1'b1;
    m_hdr_ready = 1'b1;
    cyc();
    s_hdr_valid = 1'b0;
    chk("t1_valid", 64'(m_hdr_valid), 64'd1);
    chk("t1_count1", 64'(count), 64'd1);
    chk("t1_dest", 64'(m_hdr_dest_mac), 64'hFFFF_FFFF_FFFF);
    chk("t1_src", 64'(m_hdr_src_mac), 64'h0200_0000_0001);
    chk("t1_type", 64'(m_hdr_eth_type), 64'h0806);
    chk("t1_tci0", 64'(m_hdr_vlan_tci), 64'h0);
    cyc();
    chk("t1_count0", 64'(count), 64'd0);
    chk("t1_valid0", 64'(m_hdr_valid), 64'd0);
    // fill past full with the consumer stalled
    m_hdr_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_hdr(i);
      s_hdr_valid = 1'b1;
      chk("t2_ready_pre", 64'(s_hdr_ready), 64'(i < 16));
      cyc();
      chk("t2_count", 64'(count), 64'(i < 16 ? i + 1 : 16));
      chk("t2_af", 64'(almost_full), 64'(i >= 11));
      chk("t2_head", 64'(m_hdr_dest_mac), 64'(dest_of(0)));
    end
    chk("t2_full_ready", 64'(s_hdr_ready), 64'd0);
    // full with push and pop offered: only the pop happens
    set_hdr(99);
    m_hdr_ready = 1'b1;
    cyc();
    s_hdr_valid = 1'b0;
    m_hdr_ready = 1'b0;
    chk("t3_count", 64'(count), 64'd15);
    chk("t3_ready", 64'(s_hdr_ready), 64'd1);
    m_hdr_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk("t2_drain_valid", 64'(m_hdr_valid), 64'd1);
      chk("t2_drain_id", 64'(m_hdr_dest_mac), 64'(dest_of(i)));
      cyc();
    end
    chk("t2_empty", 64'(m_hdr_valid), 64'd0);
    chk("t2_empty_count", 64'(count), 64'd0);
    // steady push+pop at occupancy 5 across several pointer wraps
    m_hdr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_hdr(i);
      s_hdr_valid = 1'b1;
      cyc();
    end
    chk("t4_count5", 64'(count), 64'd5);
    m_hdr_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      set_hdr(k + 5);
      chk("t4_order", 64'(m_hdr_dest_mac), 64'(dest_of(k)));
      cyc();
      chk("t4_count", 64'(count), 64'd5);
    end
    m_hdr_ready = 1'b0;
    set_hdr(45);
    cyc();
    set_hdr(46);
    cyc();
    chk("t5_count7", 64'(count), 64'd7);
    chk("t5_head", 64'(m_hdr_dest_mac), 64'(dest_of(40)));
    // flush drops contents and the push offered in the same cycle
    set_hdr(47);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    s_hdr_valid = 1'b0;
    chk("t5_count0", 64'(count), 64'd0);
    chk("t5_valid0", 64'(m_hdr_valid), 64'd0);
    set_hdr(200);
    s_hdr_valid = 1'b1;
    cyc();
    s_hdr_valid = 1'b0;
    chk("t5_after_count", 64'(count), 64'd1);
    chk("t5_after_head", 64'(m_hdr_dest_mac), 64'(dest_of(200)));
    m_hdr_ready = 1'b1;
    cyc();
    m_hdr_ready = 1'b0;
    // VLAN TCI kept only by the VLAN-enabled instance
    set_hdr(7);
    s_hdr_vlan_tci = 16'h6064;
    s_hdr_valid = 1'b1;
    cyc();
    s_hdr_valid = 1'b0;
    chk("t6_v_valid", 64'(v_m_valid), 64'd1);
    chk("t6_v_tci", 64'(v_tci), 64'h6064);
    chk("t6_v_type", 64'(v_type), 64'h0807);
    chk("t6_tci_novlan", 64'(m_hdr_vlan_tci), 64'h0);
    chk("t6_dest", 64'(m_hdr_dest_mac), 64'(dest_of(7)));
    // reset with a header held, plus flush at the same time
    set_hdr(8);
    s_hdr_valid = 1'b1;
    cyc();
    reset = 1'b1;
    flush = 1'b1;
    #1;
    chk("rst_mid_ready", 64'(s_hdr_ready), 64'd0);
    cyc();
    reset = 1'b0;
    flush = 1'b0;
    s_hdr_valid = 1'b0;
    #1;
    chk("rst_mid_count", 64'(count), 64'd0);
    chk("rst_mid_valid", 64'(m_hdr_valid), 64'd0);
    chk("rst_mid_v_valid", 64'(v_m_valid), 64'd0);
    chk("rst_mid_data", 64'(m_hdr_dest_mac), 64'd0);
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
